// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// SERIAL_SUB_OVF_EN (defined in serial_sub.sv users' build) enables the signed-overflow output.
package serial_sub_pkg;

  localparam int N_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_sub_fs.sv
// Combinational full-subtractor cell: d = a - b - bin for one bit.
module fs (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~a & bin) | (b & bin);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial N-bit subtractor D = A - B - bin, LSB first over N cycles.
// Optional macro SERIAL_SUB_OVF_EN adds the registered signed-overflow output ovf.
//
// Handshake: start is sampled only while busy=0 (IDLE or DONE); the accepting edge
// captures a/b/bin and raises busy. busy stays high for exactly N cycles, then valid
// rises with d/bout and holds until the next accepted start. busy and valid are
// mutually exclusive.
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter  int N  = N_DEF,
  localparam int CW = $clog2(N) + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic [N-1:0] d,
  output logic         bout,
  output logic         busy,
  output logic         valid,
`ifdef SERIAL_SUB_OVF_EN
  output logic         ovf,
`endif
  output logic [1:0]   dbg_state
);

  state_t          r_state;
  logic [N-1:0]    r_a;
  logic [N-1:0]    r_b;
  logic [N-1:0]    r_res;
  logic            r_br;
  logic [CW-1:0]   r_cnt;
  logic [N-1:0]    r_d;
  logic            r_bout;
  logic            r_busy;
  logic            r_valid;
`ifdef SERIAL_SUB_OVF_EN
  logic            r_a_msb;
  logic            r_b_msb;
  logic            r_ovf;
`endif

  logic            w_d;
  logic            w_bout;
  logic            w_last;
  logic            w_accept;

  fs u_fs (
    .a    (r_a[0]),
    .b    (r_b[0]),
    .bin  (r_br),
    .d    (w_d),
    .bout (w_bout)
  );

  assign w_last   = (r_cnt == CW'(N - 1));
  assign w_accept = start && (r_state != RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_br    <= 1'b0;
      r_cnt   <= '0;
      r_d     <= '0;
      r_bout  <= 1'b0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_ovf   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE, DONE: begin
          // DONE keeps d/bout/valid until a new start is accepted.
          if (w_accept) begin
            r_state <= RUN;
            r_a     <= a;
            r_b     <= b;
            r_br    <= bin;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_valid <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            r_a_msb <= a[N-1];
            r_b_msb <= b[N-1];
`endif
          end
        end
        RUN: begin
          r_res <= {w_d, r_res[N-1:1]};
          r_a   <= {1'b0, r_a[N-1:1]};
          r_b   <= {1'b0, r_b[N-1:1]};
          r_br  <= w_bout;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            // The final diff bit lands in the MSB of d on this same edge.
            r_state <= DONE;
            r_d     <= {w_d, r_res[N-1:1]};
            r_bout  <= w_bout;
            r_busy  <= 1'b0;
            r_valid <= 1'b1;
`ifdef SERIAL_SUB_OVF_EN
            r_ovf   <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
`endif
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign d         = r_d;
  assign bout      = r_bout;
  assign busy      = r_busy;
  assign valid     = r_valid;
  assign dbg_state = r_state;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf       = r_ovf;
`endif

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub (N=4) with an expected-result queue.
// Honours SERIAL_SUB_OVF_EN when the design is built with it.
module tb_serial_sub;

  localparam int N = 4;
  localparam int W = N + 2;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         bin;
  logic [N-1:0] d;
  logic         bout;
  logic         busy;
  logic         valid;
  logic [1:0]   dbg_state;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  logic [W-1:0] exp_q[$];
  int           n_cmp;
  int           n_err;
  logic         prev_valid;

  serial_sub #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .d         (d),
    .bout      (bout),
    .busy      (busy),
    .valid     (valid),
`ifdef SERIAL_SUB_OVF_EN
    .ovf       (ovf),
`endif
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: {ovf, bout, d} from plain arithmetic
  function automatic logic [W-1:0] model(input logic [N-1:0] ma, input logic [N-1:0] mb,
                                         input logic mbin);
    logic [N:0] full;
    logic       mo;
    full = {1'b0, ma} - {1'b0, mb} - {{N{1'b0}}, mbin};
    mo   = (ma[N-1] != mb[N-1]) && (full[N-1] != ma[N-1]);
    return {mo, full[N], full[N-1:0]};
  endfunction

  // scoreboard: pop on every rising valid
  initial prev_valid = 1'b0;
  always @(negedge clk) begin
    logic [W-1:0] e;
    chk("busy_valid_excl", {31'd0, busy & valid}, 32'd0);
    if (valid && !prev_valid) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_result", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("d", {28'd0, d}, {28'd0, e[N-1:0]});
        chk("bout", {31'd0, bout}, {31'd0, e[N]});
`ifdef SERIAL_SUB_OVF_EN
        chk("ovf", {31'd0, ovf}, {31'd0, e[N+1]});
`endif
      end
    end
    prev_valid = valid;
  end

  task automatic wait_valid(output int busy_cnt);
    bit got;
    busy_cnt = 0;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (valid) begin
        got = 1;
        break;
      end
      if (busy) busy_cnt++;
    end
    if (!got) chk("valid_timeout", 32'd0, 32'd1);
  endtask

  // driver: one full operation from an idle/done state
  task automatic run_op(input logic [N-1:0] ta, input logic [N-1:0] tb, input logic tbin);
    int cnt;
    @(negedge clk);
    a = ta;
    b = tb;
    bin = tbin;
    start = 1'b1;
    exp_q.push_back(model(ta, tb, tbin));
    @(posedge clk);
    #1;
    start = 1'b0;
    a = N'($urandom_range(0, (1 << N) - 1));
    b = N'($urandom_range(0, (1 << N) - 1));
    bin = 1'($urandom_range(0, 1));
    chk("valid_fall", {31'd0, valid}, 32'd0);
    chk("busy_rise", {31'd0, busy}, 32'd1);
    wait_valid(cnt);
    chk("busy_cycles", cnt, N);
  endtask

  initial begin
    int cnt;
    n_cmp = 0;
    n_err = 0;
    start = 1'b0;
    a = '0;
    b = '0;
    bin = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_d", {28'd0, d}, 32'd0);
    chk("rst_bout", {31'd0, bout}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_state", {30'd0, dbg_state}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(4'd9, 4'd3, 1'b0);
    run_op(4'd3, 4'd9, 1'b0);
    run_op(4'd0, 4'd0, 1'b1);
    run_op(4'd15, 4'd15, 1'b0);

    // start held high through RUN with changing operands: no recapture, no restart
    @(negedge clk);
    a = 4'd9;
    b = 4'd3;
    bin = 1'b0;
    start = 1'b1;
    exp_q.push_back(model(4'd9, 4'd3, 1'b0));
    @(posedge clk);
    #1;
    a = 4'd1;
    b = 4'd1;
    for (int i = 0; i < N - 1; i++) begin
      @(posedge clk);
      #1;
      chk("hold_busy", {31'd0, busy}, 32'd1);
    end
    start = 1'b0;
    wait_valid(cnt);
    @(negedge clk);
    chk("hold_no_restart", {31'd0, busy}, 32'd0);
    chk("hold_valid_kept", {31'd0, valid}, 32'd1);

    // asynchronous reset mid-operation clears everything immediately
    @(negedge clk);
    a = 4'd12;
    b = 4'd1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_valid", {31'd0, valid}, 32'd0);
    chk("abort_d", {28'd0, d}, 32'd0);
    chk("abort_bout", {31'd0, bout}, 32'd0);
    chk("abort_state", {30'd0, dbg_state}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_op(4'd5, 4'd2, 1'b0);

    // restart straight from DONE
    run_op(4'd7, 4'b1111, 1'b0);

    for (int i = 0; i < 8; i++) begin
      run_op(N'($urandom_range(0, 15)), N'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    chk("sb_drain", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
